// File: rtl/nios_switch_event_ctrl.sv
// Avalon-MM master that services a switch edge-capture PIO on its own: programs irq_mask,
// answers the PIO irq by reading/clearing edge_capture and sampling levels, and queues events.
module nios_switch_event_ctrl #(
  parameter int               WIDTH      = 2,
  parameter int               FIFO_DEPTH = 4,
  parameter logic [WIDTH-1:0] INIT_MASK  = 2'b11
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          pio_irq,
  output logic [1:0]                    pio_address,
  output logic                          pio_chipselect,
  output logic                          pio_write_n,
  output logic [31:0]                   pio_writedata,
  input  logic [31:0]                   pio_readdata,
  input  logic [WIDTH-1:0]              cfg_mask,
  input  logic                          cfg_mask_wr,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [WIDTH-1:0]              evt_capture,
  output logic [WIDTH-1:0]              evt_level,
  output logic [$clog2(FIFO_DEPTH):0]   evt_count,
  output logic                          overflow,
  input  logic                          overflow_clr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_CAP  = 2'd3;

  localparam logic [PTR_W:0] PTR_ONE    = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0] FULL_COUNT = FIFO_DEPTH[PTR_W:0];

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_MASK, S_RD_CAP, S_CLR_CAP, S_RD_DAT, S_PUSH
  } state_t;

  typedef struct packed {
    logic        cs;
    logic        wr_n;
    logic [1:0]  addr;
    logic [31:0] wdata;
  } bus_t;

  localparam bus_t BUS_IDLE = '{cs: 1'b0, wr_n: 1'b1, addr: ADDR_DATA, wdata: 32'd0};

  function automatic bus_t bus_write(input logic [1:0] addr, input logic [WIDTH-1:0] data);
    bus_t b;
    b.cs    = 1'b1;
    b.wr_n  = 1'b0;
    b.addr  = addr;
    b.wdata = {{(32-WIDTH){1'b0}}, data};
    return b;
  endfunction

  function automatic bus_t bus_read(input logic [1:0] addr);
    bus_t b;
    b.cs    = 1'b1;
    b.wr_n  = 1'b1;
    b.addr  = addr;
    b.wdata = 32'd0;
    return b;
  endfunction

  state_t           state, state_nxt;
  bus_t             bus, bus_nxt;
  logic [WIDTH-1:0] cap_reg;
  logic [WIDTH-1:0] mask_val;
  logic             mask_pend;

  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic [2*WIDTH-1:0] mem [FIFO_DEPTH];
  logic             full, push_req, push, pop, drop;
  logic [WIDTH-1:0] level_in;

  // Upper read-data bits carry nothing for a WIDTH-bit PIO.
  logic unused_readdata;
  assign unused_readdata = ^pio_readdata[31:WIDTH];

  // Bus outputs are registered from the next state, so the bus always shows the
  // access belonging to the state the FSM is in; INIT's write lands on the first IDLE cycle.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    bus_nxt   = BUS_IDLE;
    unique case (state)
      S_INIT: begin
        state_nxt = S_IDLE;
        bus_nxt   = bus_write(ADDR_MASK, INIT_MASK);
      end
      S_IDLE: begin
        if (mask_pend) begin
          state_nxt = S_MASK;
          bus_nxt   = bus_write(ADDR_MASK, mask_val);
        end else if (pio_irq) begin
          state_nxt = S_RD_CAP;
          bus_nxt   = bus_read(ADDR_CAP);
        end
      end
      S_MASK:    state_nxt = S_IDLE;
      S_RD_CAP: begin
        state_nxt = S_CLR_CAP;
        bus_nxt   = bus_write(ADDR_CAP, '0);
      end
      S_CLR_CAP: begin
        state_nxt = S_RD_DAT;
        bus_nxt   = bus_read(ADDR_DATA);
      end
      S_RD_DAT:  state_nxt = S_PUSH;
      S_PUSH:    state_nxt = S_IDLE;
      default:   state_nxt = S_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_INIT;
      bus   <= BUS_IDLE;
    end else begin
      state <= state_nxt;
      bus   <= bus_nxt;
    end
  end

  assign pio_chipselect = bus.cs;
  assign pio_write_n    = bus.wr_n;
  assign pio_address    = bus.addr;
  assign pio_writedata  = bus.wdata;

  // A pulse arriving while a pending write is being dispatched stays pending, so the newest value always reaches the PIO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_val  <= '0;
      mask_pend <= 1'b0;
    end else if (cfg_mask_wr) begin
      mask_val  <= cfg_mask;
      mask_pend <= 1'b1;
    end else if (state == S_IDLE && mask_pend) begin
      mask_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_reg <= '0;
    end else if (state == S_CLR_CAP) begin
      cap_reg <= pio_readdata[WIDTH-1:0];
    end
  end

  // Event FIFO: first-word-fall-through, occupancy from pointers with an extra wrap bit.
  assign level_in  = pio_readdata[WIDTH-1:0];
  assign evt_count = wr_ptr - rd_ptr;
  assign evt_valid = (evt_count != '0);
  assign full      = (evt_count == FULL_COUNT);
  assign pop       = evt_valid & evt_ready;
  assign push_req  = (state == S_PUSH) && (cap_reg != '0);
  assign push      = push_req & (~full | pop);
  assign drop      = push_req & full & ~pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= {cap_reg, level_in};
  end

  assign {evt_capture, evt_level} = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nios_switch_event_ctrl.sv
// Directed bench for nios_switch_event_ctrl driving a behavioural 2-bit edge-capture PIO.
module tb_nios_switch_event_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pio_irq;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [31:0] pio_readdata;
  logic [1:0]  cfg_mask = 2'b00;
  logic        cfg_mask_wr = 1'b0;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic [1:0]  evt_capture;
  logic [1:0]  evt_level;
  logic [2:0]  evt_count;
  logic        overflow;
  logic        overflow_clr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nios_switch_event_ctrl #(.WIDTH(2), .FIFO_DEPTH(4), .INIT_MASK(2'b11)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pio_irq        (pio_irq),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata),
    .pio_readdata   (pio_readdata),
    .cfg_mask       (cfg_mask),
    .cfg_mask_wr    (cfg_mask_wr),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_capture    (evt_capture),
    .evt_level      (evt_level),
    .evt_count      (evt_count),
    .overflow       (overflow),
    .overflow_clr   (overflow_clr)
  );

  // Switch PIO: any-edge capture, write to edge_capture clears it, registered readdata.
  logic [1:0] sw = 2'b00;
  logic [1:0] sw_d, edge_cap, irq_mask;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_d         <= 2'b00;
      edge_cap     <= 2'b00;
      irq_mask     <= 2'b00;
      pio_readdata <= 32'd0;
    end else begin
      sw_d <= sw;
      case (pio_address)
        2'd0:    pio_readdata <= {30'd0, sw};
        2'd2:    pio_readdata <= {30'd0, irq_mask};
        2'd3:    pio_readdata <= {30'd0, edge_cap};
        default: pio_readdata <= 32'd0;
      endcase
      if (pio_chipselect && !pio_write_n && pio_address == 2'd2) irq_mask <= pio_writedata[1:0];
      if (pio_chipselect && !pio_write_n && pio_address == 2'd3) edge_cap <= 2'b00;
      else edge_cap <= edge_cap | (sw ^ sw_d);
    end
  end

  assign pio_irq = |(edge_cap & irq_mask);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_irq(input string tag);
    int k;
    for (k = 0; k < 20 && !pio_irq; k++) tick();
    if (!pio_irq) check({tag, "_irq_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_bus(input string tag, input logic cs, input logic wr_n,
                           input logic [1:0] addr, input logic [31:0] wdata);
    check({tag, "_cs"},    {31'd0, pio_chipselect}, {31'd0, cs});
    check({tag, "_wr_n"},  {31'd0, pio_write_n},    {31'd0, wr_n});
    check({tag, "_addr"},  {30'd0, pio_address},    {30'd0, addr});
    check({tag, "_wdata"}, pio_writedata,           wdata);
  endtask

  task automatic check_head(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, evt_capture, evt_level}, {28'd0, exp});
  endtask

  task automatic toggle(input logic [1:0] bits, input int settle);
    sw = sw ^ bits;
    tick(settle);
  endtask

  logic [3:0] exp3 [4] = '{4'b1011, 4'b0110, 4'b1000, 4'b0101};
  logic [1:0] tog3 [5] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b11};

  initial begin
    // Reset state and the one-time irq_mask write
    tick(2);
    check_bus("rst", 1'b0, 1'b1, 2'd0, 32'd0);
    check("rst_valid", {31'd0, evt_valid}, 32'd0);
    check("rst_count", {29'd0, evt_count}, 32'd0);
    check("rst_ovf",   {31'd0, overflow},  32'd0);
    reset_n = 1'b1;
    tick();
    check_bus("init", 1'b1, 1'b0, 2'd2, 32'd3);
    tick();
    check("init_idle_cs", {31'd0, pio_chipselect}, 32'd0);
    check("init_pio_mask", {30'd0, irq_mask}, 32'd3);

    // Single event 00->01 with latency measured from irq seen in IDLE
    evt_ready = 1'b1;
    sw = 2'b01;
    wait_irq("lat");
    tick(4);
    check("lat_valid_c4", {31'd0, evt_valid}, 32'd0);
    tick();
    check("lat_valid_c5", {31'd0, evt_valid}, 32'd1);
    check_head("lat_head", 4'b0101);
    check("lat_irq_low", {31'd0, pio_irq}, 32'd0);
    tick();
    check("lat_popped", {29'd0, evt_count}, 32'd0);
    evt_ready = 1'b0;

    // Five events into a 4-deep FIFO: the fifth is dropped
    for (int i = 0; i < 4; i++) toggle(tog3[i], 8);
    check("fill_count", {29'd0, evt_count}, 32'd4);
    check("fill_ovf",   {31'd0, overflow},  32'd0);
    toggle(tog3[4], 8);
    check("drop_count", {29'd0, evt_count}, 32'd4);
    check("drop_ovf",   {31'd0, overflow},  32'd1);
    for (int i = 0; i < 4; i++) begin
      check_head($sformatf("drain_%0d", i), exp3[i]);
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
    end
    check("drain_count", {29'd0, evt_count}, 32'd0);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check("empty_pop_count", {29'd0, evt_count}, 32'd0);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("ovf_cleared", {31'd0, overflow}, 32'd0);

    // Mask request during PUSH with a new irq pending: MASK write precedes RD_CAP
    sw = sw ^ 2'b01;
    wait_irq("mask");
    tick(4);
    sw = sw ^ 2'b10;
    cfg_mask = 2'b10;
    cfg_mask_wr = 1'b1;
    tick();
    cfg_mask_wr = 1'b0;
    check("mask_c5_cs", {31'd0, pio_chipselect}, 32'd0);
    tick();
    check_bus("mask_wr", 1'b1, 1'b0, 2'd2, 32'd2);
    tick();
    check("mask_c7_cs", {31'd0, pio_chipselect}, 32'd0);
    tick();
    check_bus("mask_rdcap", 1'b1, 1'b1, 2'd3, 32'd0);
    tick(6);
    check("mask_count", {29'd0, evt_count}, 32'd2);
    check_head("mask_head0", 4'b0111);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check_head("mask_head1", 4'b1001);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    cfg_mask = 2'b11;
    cfg_mask_wr = 1'b1;
    tick();
    cfg_mask_wr = 1'b0;
    tick(4);
    check("mask_restored", {30'd0, irq_mask}, 32'd3);

    // Full FIFO with a pop in the PUSH cycle: no drop
    for (int i = 0; i < 4; i++) toggle(tog3[i], 8);
    check("full_count", {29'd0, evt_count}, 32'd4);
    sw = sw ^ 2'b11;
    wait_irq("fullpop");
    tick(4);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check("fullpop_count", {29'd0, evt_count}, 32'd4);
    check("fullpop_ovf",   {31'd0, overflow},  32'd0);
    check_head("fullpop_head", 4'b0110);

    // Asynchronous reset during CLR_CAP
    sw = sw ^ 2'b01;
    wait_irq("arst");
    tick(2);
    check_bus("arst_clr", 1'b1, 1'b0, 2'd3, 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check_bus("arst", 1'b0, 1'b1, 2'd0, 32'd0);
    check("arst_valid", {31'd0, evt_valid}, 32'd0);
    check("arst_count", {29'd0, evt_count}, 32'd0);
    check("arst_ovf",   {31'd0, overflow},  32'd0);
    tick(2);
    reset_n = 1'b1;
    tick();
    check_bus("reinit", 1'b1, 1'b0, 2'd2, 32'd3);
    check("reinit_count", {29'd0, evt_count}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
